// File: rtl/execute_pkg.sv
// Shared definitions for the MIPS execute stage: ALU opcodes, mult/div FSM states
// and the constant returned as the quotient of a divide by zero.
package execute_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_BUSY  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative signed multiply/divide unit owning HI/LO: one radix-2 step per cycle on
// unsigned magnitudes, with signs applied in a final FIXUP cycle.
module muldiv_unit
  import execute_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(MD_ITER);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        isDiv_q, isDiv_d;
  logic        signA_q, signA_d;
  logic        signB_q, signB_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] addSum;
  logic [32:0] remShift;
  logic [32:0] remDiff;
  logic [63:0] prodSigned;
  logic [31:0] quotSigned;
  logic [31:0] remSigned;

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
  always_comb begin
    addSum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    remShift   = acc_q[63:31];
    remDiff    = remShift - {1'b0, opnd_q};
    prodSigned = (signA_q ^ signB_q) ? (~acc_q + 64'd1) : acc_q;
    quotSigned = (signA_q ^ signB_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    remSigned  = signA_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    isDiv_d = isDiv_q;
    signA_d = signA_q;
    signB_d = signB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = '0;
          isDiv_d = op_i;
          signA_d = a_i[31];
          signB_d = b_i[31];
          acc_d   = {32'd0, abs32(a_i)};
          opnd_d  = abs32(b_i);
        end
      end
      MD_BUSY: begin
        if (isDiv_q) begin
          acc_d = remDiff[32] ? {remShift[31:0], acc_q[30:0], 1'b0}
                              : {remDiff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {addSum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MD_ITER - 1)) begin
          state_d = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        state_d = MD_IDLE;
        // With a zero divisor the remainder path already reproduces A in HI.
        if (isDiv_q) begin
          lo_d = (opnd_q == 32'd0) ? DIV_ZERO_QUOT : quotSigned;
          hi_d = remSigned;
        end else begin
          {hi_d, lo_d} = prodSigned;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      isDiv_q <= 1'b0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      isDiv_q <= isDiv_d;
      signA_q <= signA_d;
      signB_q <= signB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU, beq/j redirect, HI/LO access through
// the mult/div unit, and the EX/MEM pipeline register.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MD_ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] DX_PC,
  input  logic [DW-1:0] JAddr,
  input  logic          Jump,
  input  logic          Branch,
  input  logic          DX_MemWrite,
  input  logic          DX_MemToReg,
  input  logic          DX_RegWrite,
  input  logic          lhWrite,
  input  logic          lhRead,
  input  logic          mflo,
  input  logic          ALUSrc,
  input  logic [2:0]    ALUCtr,
  input  logic [4:0]    RD,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] Imm,
  output logic          pc_redirect,
  output logic [DW-1:0] pc_target,
  output logic          md_stall,
  output logic [DW-1:0] XM_ALUout,
  output logic [DW-1:0] XM_B,
  output logic [4:0]    XM_RD,
  output logic          XM_MemWrite,
  output logic          XM_MemToReg,
  output logic          XM_RegWrite
);

  logic [DW-1:0] op2;
  logic [DW-1:0] aluResult;
  logic [DW-1:0] mdHi;
  logic [DW-1:0] mdLo;
  logic          mdBusy;
  logic          mdStart;
  logic          isCtrlFlow;

  logic [DW-1:0] xmAluOut_q, xmAluOut_d;
  logic [DW-1:0] xmB_q, xmB_d;
  logic [4:0]    xmRd_q, xmRd_d;
  logic          xmMemWrite_q, xmMemWrite_d;
  logic          xmMemToReg_q, xmMemToReg_d;
  logic          xmRegWrite_q, xmRegWrite_d;

  always_comb begin
    op2 = ALUSrc ? Imm : B;
    case (ALUCtr)
      ALU_ADD: aluResult = A + op2;
      ALU_SUB: aluResult = A - op2;
      ALU_AND: aluResult = A & op2;
      ALU_OR:  aluResult = A | op2;
      ALU_SLT: aluResult = ($signed(A) < $signed(op2)) ? DW'(1) : '0;
      default: aluResult = '0;
    endcase
  end

  // Only MD instructions ever wait on the unit; everything else flows through BUSY.
  assign md_stall    = (lhWrite | lhRead) & mdBusy;
  assign mdStart     = lhWrite & ~mdBusy;
  assign isCtrlFlow  = Jump | Branch;
  assign pc_redirect = (Jump | (Branch & (A == B))) & ~md_stall;
  assign pc_target   = Jump ? JAddr : DX_PC + {Imm[DW-3:0], 2'b00};

  muldiv_unit #(
    .MD_ITER(MD_ITER)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start_i(mdStart),
    .op_i   (mflo),
    .a_i    (A),
    .b_i    (B),
    .busy_o (mdBusy),
    .hi_o   (mdHi),
    .lo_o   (mdLo)
  );

  // A stalled instruction leaves a bubble behind; its data fields are don't-care.
  always_comb begin
    xmAluOut_d   = lhRead ? (mflo ? mdLo : mdHi) : aluResult;
    xmB_d        = B;
    xmRd_d       = RD;
    xmRegWrite_d = DX_RegWrite & ~lhWrite & ~isCtrlFlow & ~md_stall;
    xmMemWrite_d = DX_MemWrite & ~isCtrlFlow & ~md_stall;
    xmMemToReg_d = DX_MemToReg & ~md_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmAluOut_q   <= '0;
      xmB_q        <= '0;
      xmRd_q       <= '0;
      xmMemWrite_q <= 1'b0;
      xmMemToReg_q <= 1'b0;
      xmRegWrite_q <= 1'b0;
    end else begin
      xmAluOut_q   <= xmAluOut_d;
      xmB_q        <= xmB_d;
      xmRd_q       <= xmRd_d;
      xmMemWrite_q <= xmMemWrite_d;
      xmMemToReg_q <= xmMemToReg_d;
      xmRegWrite_q <= xmRegWrite_d;
    end
  end

  assign XM_ALUout   = xmAluOut_q;
  assign XM_B        = xmB_q;
  assign XM_RD       = xmRd_q;
  assign XM_MemWrite = xmMemWrite_q;
  assign XM_MemToReg = xmMemToReg_q;
  assign XM_RegWrite = xmRegWrite_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register (DX_* bundle) produced by the decode stage and performs the ALU operation.
- Resolves beq/j redirect toward fetch.
- Owns the HI/LO registers and an iterative signed mult/div unit.
- Produces the EX/MEM pipeline register (XM_* bundle) and a stall toward fetch/decode while mult/div or mfhi/mflo must wait.

Parameters:
- DW, 32, datapath width. Only 32 is supported and verified.
- MD_ITER, 32, mult/div iterations. Must equal DW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- DX_PC  in  32  PC+4 of the instruction in EX
- JAddr  in  32  jump target
- Jump, Branch  in  1 each  j / beq flags
- DX_MemWrite, DX_MemToReg, DX_RegWrite  in  1 each  memory/writeback controls
- lhWrite  in  1  mult/div issue; mflo=0 selects mult, mflo=1 selects div
- lhRead  in  1  mfhi/mflo; mflo=1 selects LO, mflo=0 selects HI
- mflo  in  1  HI/LO or mult/div select
- ALUSrc  in  1  1 selects Imm as operand B
- ALUCtr  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- RD  in  5  destination register
- A, B, Imm  in  32 each  operands, sign-extended immediate
- pc_redirect  out  1  fetch must take pc_target (combinational)
- pc_target  out  32  redirect address (combinational)
- md_stall  out  1  upstream holds DX_* stable this cycle (combinational)
- XM_ALUout  out  32  result or memory address
- XM_B  out  32  store data
- XM_RD  out  5  destination register
- XM_MemWrite, XM_MemToReg, XM_RegWrite  out  1 each  forwarded controls

Behaviour:
- Reset: every XM_* output is 0. HI=LO=0. MD FSM goes to IDLE with counter 0. A reset mid-operation aborts the operation; no HI/LO update occurs.
- ALU: op2 = ALUSrc ? Imm : B.
  - add/sub wrap modulo 2^32; there is no overflow trap.
  - slt is a signed compare giving 32'd1 or 32'd0.
  - Any undefined ALUCtr value gives 0.
- Redirect:
  - pc_redirect = Jump | (Branch & (A==B)).
  - pc_target = Jump ? JAddr : DX_PC + {Imm[29:0],2'b00}.
  - Jump has priority over Branch.
  - pc_redirect is forced 0 while md_stall=1.
- XM register updates every posedge. Latency is 1 cycle.
  - XM_ALUout = lhRead ? (mflo ? LO : HI) : ALU result.
  - XM_B = B.
  - XM_RD = RD.
  - XM_RegWrite = DX_RegWrite & ~lhWrite. Mult/div never writes the GPR file.
  - Jump/Branch instructions force XM_RegWrite=0 and XM_MemWrite=0.
- MD FSM states:
  - IDLE -> BUSY: on an edge with lhWrite=1 and state IDLE. Latch |A|, |B|, the sign bits and the op; counter=0.
  - BUSY: one radix-2 iteration per edge. Mult is shift-add on a 64-bit accumulator. Div is restoring division (quotient/remainder). BUSY -> FIXUP on the edge where counter==MD_ITER-1.
  - FIXUP -> IDLE: apply signs and write HI/LO.
    - Mult: {HI,LO} = signed 64-bit product.
    - Div: LO = quotient, negated when sign(A) != sign(B). HI = remainder carrying the sign of A.
    - Divide by zero: LO = 32'hFFFFFFFF, HI = A; no exception.
- Timing: with issue at edge T, HI/LO are valid after edge T+MD_ITER+1 (T+33).
- md_stall = (lhWrite | lhRead) & (state != IDLE).
  - While md_stall=1, the XM bundle loads a bubble: XM_RegWrite=0, XM_MemWrite=0, XM_MemToReg=0. XM_ALUout, XM_B and XM_RD are don't-care.
  - No new MD op is accepted while md_stall=1.
  - Non-MD instructions proceed normally during BUSY.
- Simultaneous events:
  - An lhRead in the same cycle the FSM leaves FIXUP is stalled. The following cycle it reads the new HI/LO.
  - Back-to-back lhWrite: the second one stalls until IDLE.

Decomposition:
- Shared package execute_pkg holds:
  - ALUCtr codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - MD state encoding: MD_IDLE, MD_BUSY, MD_FIXUP.
  - Divide-by-zero quotient constant.
- One sub-module, muldiv_unit. It owns the FSM, counter, accumulators and HI/LO. Its interface is start/op/a/b in and busy/hi/lo out.
- The ALU, redirect logic and XM register stay in execute_stage.

Test Plan:
- Reset then ALU: ALUCtr=010, A=7, Imm=-3, ALUSrc=1 -> next edge XM_ALUout=4. slt with A=-1, B=1 -> XM_ALUout=1. All XM_* are 0 during rst.
- Redirect: Branch=1, A=B=5, DX_PC=0x100, Imm=-2 -> pc_redirect=1, pc_target=0xF8, XM_RegWrite=0. Jump=1 with Branch=1 -> pc_target=JAddr.
- Mult: issue A=-3, B=7, then independent adds, then mflo -> md_stall=1 until state IDLE. The mflo returns 0xFFFFFFEB; mfhi returns 0xFFFFFFFF. HI/LO change exactly after edge T+33.
- Div: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. A=9, B=0 -> LO=0xFFFFFFFF, HI=9.
- Back-to-back mult then div -> the div is stalled 33 cycles and bubbles appear on XM. A final mfhi reflects the div result only.
- Reset asserted mid-BUSY (edge T+10) -> HI=LO=0, md_stall=0 next cycle, and a subsequent mult completes correctly.
